mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares one single-port, variable-latency memory between the pipeline's instruction-fetch (IF) port and data-access (MEM) port. It grants one access at a time, drives the memory handshake, and returns read data with a one-cycle ready pulse. It produces per-port stall signals that the hazard logic uses to gate `pcWrite`/`ifidWrite` and freeze the later stages. It sits between the pipeline datapath and the shared memory.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter sharing one single-port variable-latency memory.
// Optional bus timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        IF_ACC,
        MEM_ACC,
        RESP_IF,
        RESP_MEM
    } state_t;

    state_t state, state_nx;
    logic   in_acc;
    logic   timeout_hit;
    logic   if_denied;

    assign in_acc = (state == IF_ACC) || (state == MEM_ACC);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    // IDLE always precedes an access, so clearing there clears on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE)
                to_cnt <= '0;
            else if (in_acc && !ram_ack)
                to_cnt <= to_cnt + 1'b1;
            if (timeout_hit)
                bus_err <= 1'b1;
        end
    end

    assign timeout_hit = in_acc && !ram_ack && (to_cnt == TW'(TIMEOUT));
`else
    logic cfg_unused;
    assign cfg_unused  = (TIMEOUT != 0);
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mem_req)
                    state_nx = MEM_ACC;
                else if (if_req)
                    state_nx = IF_ACC;
            end
            IF_ACC:   if (ram_ack || timeout_hit) state_nx = RESP_IF;
            MEM_ACC:  if (ram_ack || timeout_hit) state_nx = RESP_MEM;
            RESP_IF:  state_nx = IDLE;
            RESP_MEM: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // IF loses a cycle whenever MEM owns or is about to own the memory.
    assign if_denied = if_req && !if_ready &&
                       ((state == MEM_ACC) || (state == RESP_MEM) ||
                        ((state == IDLE) && mem_req));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ram_req      <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            if_ready     <= 1'b0;
            mem_ready    <= 1'b0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            state     <= state_nx;
            ram_req   <= (state_nx == IF_ACC) || (state_nx == MEM_ACC);
            if_ready  <= (state_nx == RESP_IF);
            mem_ready <= (state_nx == RESP_MEM);

            if (state == IDLE) begin
                if (mem_req) begin
                    ram_we    <= mem_we;
                    ram_addr  <= mem_addr;
                    ram_wdata <= mem_wdata;
                end else if (if_req) begin
                    ram_we   <= 1'b0;
                    ram_addr <= if_addr;
                end
            end

            if (state == IF_ACC) begin
                if (ram_ack)
                    if_rdata <= ram_rdata;
                else if (timeout_hit)
                    if_rdata <= '0;
            end

            if ((state == MEM_ACC) && !ram_we) begin
                if (ram_ack)
                    mem_rdata <= ram_rdata;
                else if (timeout_hit)
                    mem_rdata <= '0;
            end

            if (if_denied && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign stall_if  = if_req && !if_ready;
    assign stall_mem = mem_req && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              ram_ack = 1'b0;
    logic [CNT_W-1:0]  conflict_cnt;
    logic              bus_err;

    mem_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .conflict_cnt(conflict_cnt), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural memory: 16 words, wait cycles drawn from [wait_lo, wait_hi].
    logic [31:0] mem_arr [16];
    int  wait_lo = 0, wait_hi = 0;
    bit  mute = 0, noise = 0;
    bit  r_busy = 0;
    int  r_wc = 0, r_wt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic respond();
        if (!rst) begin
            r_busy  = 0;
            ram_ack = 1'b0;
        end else if (ram_req) begin
            if (!r_busy) begin
                r_busy = 1;
                r_wc   = 0;
                r_wt   = $urandom_range(wait_hi, wait_lo);
            end
            if (!mute && r_wc == r_wt) begin
                ram_ack = 1'b1;
                if (ram_we) mem_arr[ram_addr[5:2]] = ram_wdata;
                else        ram_rdata = mem_arr[ram_addr[5:2]];
                r_busy = 0;
            end else begin
                ram_ack = 1'b0;
                r_wc++;
            end
        end else begin
            r_busy    = 0;
            ram_ack   = noise ? 1'($urandom % 2) : 1'b0;
            ram_rdata = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        tick();
        rst = 1'b1;
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic run_episode(input int ncyc);
        bit f_act = 0, m_act = 0, m_busy = 0, m_w = 0, g_mem = 0;
        bit prev_mreq = 0, prev_fwait = 0, prev_rq = 0, fwait;
        logic [31:0] f_a = 0, m_a = 0, m_d = 0, g_addr = 0;
        int model_cnt = 0, f_age = 0, m_age = 0, t = 0;
        do_reset();
        wait_lo = 0; wait_hi = 3; noise = 1;
        while ((t < ncyc || f_act || m_act) && t < ncyc + 80) begin
            tick();
            if (ram_req && !prev_rq) begin
                g_mem  = prev_mreq;
                g_addr = g_mem ? m_a : f_a;
                check("grant_we", ram_we, g_mem ? m_w : 1'b0);
                if (g_mem && m_w) check("grant_wdata", ram_wdata, m_d);
                if (g_mem) begin
                    model_cnt += prev_fwait;
                    m_busy = 1;
                end
            end
            if (ram_req) check("ram_addr_stable", ram_addr, g_addr);
            check("conflict_cnt", conflict_cnt, sat(model_cnt));
            if (if_ready) begin
                check("if_ready_owner", f_act, 1);
                check("if_rdata", if_rdata, mem_arr[f_a[5:2]]);
            end
            if (mem_ready) begin
                check("mem_ready_owner", m_act, 1);
                if (!m_w) check("mem_rdata", mem_rdata, mem_arr[m_a[5:2]]);
            end
            if (if_ready) begin
                if_req = 0; f_act = 0;
            end else if (!f_act && t < ncyc && $urandom % 3 == 0) begin
                f_act = 1; f_age = 0;
                f_a = 32'($urandom_range(15, 0)) * 4;
                if_addr = f_a; if_req = 1;
            end else if (!f_act) begin
                if_addr = $urandom;
            end
            if (mem_ready) begin
                mem_req = 0; m_act = 0;
            end else if (!m_act && t < ncyc && $urandom % 3 == 0) begin
                m_act = 1; m_age = 0;
                m_a = 32'($urandom_range(15, 0)) * 4;
                m_w = 1'($urandom % 2);
                m_d = $urandom;
                mem_addr = m_a; mem_we = m_w; mem_wdata = m_d; mem_req = 1;
            end
            fwait = if_req && !if_ready;
            if (m_busy) model_cnt += fwait;
            if (mem_ready) m_busy = 0;
            prev_fwait = fwait; prev_mreq = mem_req; prev_rq = ram_req;
            if (f_act) f_age++;
            if (m_act) m_age++;
            check("if_age_bound", f_age > 60, 0);
            check("mem_age_bound", m_age > 60, 0);
            #1;
            check("stall_if", stall_if, if_req && !if_ready);
            check("stall_mem", stall_mem, mem_req && !mem_ready);
            t++;
        end
        check("quiesce", f_act || m_act, 0);
        noise = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        int cyc;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;

        // Reset values, then idle.
        rst = 1'b0;
        tick();
        check("rst_ram_req", ram_req, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_conflict", conflict_cnt, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stalls", {stall_if, stall_mem}, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ram_req", ram_req, 0);
        end

        // Zero-wait IF read; address change after grant must not matter.
        do_reset();
        wait_lo = 0; wait_hi = 0;
        mem_arr[4] = 32'h8C010004;
        if_req = 1; if_addr = 32'h10;
        #1 check("t2_stall_c0", stall_if, 1);
        tick();
        check("t2_ram_req_c1", ram_req, 1);
        check("t2_ram_addr_c1", ram_addr, 32'h10);
        check("t2_ram_we_c1", ram_we, 0);
        check("t2_stall_c1", stall_if, 1);
        if_addr = 32'h20;
        tick();
        check("t2_ram_addr_hold", ram_addr, 32'h10);
        check("t2_if_ready_c2", if_ready, 1);
        check("t2_if_rdata_c2", if_rdata, 32'h8C010004);
        check("t2_ram_req_c2", ram_req, 0);
        if_req = 0;
        tick();
        check("t2_if_ready_c3", if_ready, 0);
        check("t2_if_rdata_held", if_rdata, 32'h8C010004);

        // Simultaneous MEM write and IF read, two wait cycles.
        do_reset();
        wait_lo = 2; wait_hi = 2;
        mem_arr[0] = 32'h0;
        exp_d = mem_arr[5];
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hA5A5A5A5;
        if_req = 1; if_addr = 32'h14;
        tick();
        check("t3_ram_addr", ram_addr, 32'h100);
        check("t3_ram_we", ram_we, 1);
        check("t3_ram_wdata", ram_wdata, 32'hA5A5A5A5);
        cyc = 1;
        while (!mem_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t3_mem_latency", cyc, 4);
        check("t3_if_not_first", if_ready, 0);
        mem_req = 0;
        tick();
        check("t3_idle_gap", ram_req, 0);
        tick();
        check("t3_if_grant", ram_req, 1);
        check("t3_if_addr", ram_addr, 32'h14);
        check("t3_if_we", ram_we, 0);
        check("t3_conflict", conflict_cnt, 5);
        cyc = 0;
        while (!if_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t3_if_ready", if_ready, 1);
        check("t3_if_rdata", if_rdata, exp_d);
        check("t3_mem_written", mem_arr[0], 32'hA5A5A5A5);
        if_req = 0;

        // Reset in the middle of a MEM access.
        do_reset();
        wait_lo = 5; wait_hi = 5;
        mem_req = 1; mem_we = 0; mem_addr = 32'h8;
        tick();
        check("t4_ram_req", ram_req, 1);
        tick();
        rst = 1'b0;
        #1;
        check("t4_ram_req_drop", ram_req, 0);
        check("t4_no_ready", mem_ready, 0);
        tick();
        rst = 1'b1; mem_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_ready_after", mem_ready, 0);
        end
        wait_lo = 0; wait_hi = 0;
        exp_d = mem_arr[3];
        if_req = 1; if_addr = 32'hC;
        tick();
        check("t4_if_grant", ram_req, 1);
        tick();
        check("t4_if_ready", if_ready, 1);
        check("t4_if_rdata", if_rdata, exp_d);
        if_req = 0;
        tick();

        // Withheld acknowledge.
        do_reset();
        mem_arr[1] = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h4;
        tick();
        tick();
        check("t5_pre_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 0;
        tick();
        mute = 1;
        if_req = 1; if_addr = 32'h4;
`ifdef MEM_ARB_TIMEOUT_EN
        cyc = 0;
        while (!if_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t5_timeout_cycle", cyc, 10);
        check("t5_timeout_rdata", if_rdata, 0);
        check("t5_bus_err", bus_err, 1);
        if_req = 0;
        for (int i = 0; i < 3; i++) tick();
        check("t5_bus_err_sticky", bus_err, 1);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t5_hold_req", ram_req, 1);
            check("t5_no_ready", if_ready, 0);
        end
        check("t5_bus_err_off", bus_err, 0);
`endif
        mute = 0;
        do_reset();

        // Continuous MEM traffic saturates the conflict counter.
        wait_lo = 0; wait_hi = 0;
        mem_req = 1; mem_we = 0; mem_addr = 32'h0;
        if_req = 1; if_addr = 32'h8;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("t6_if_denied", if_ready, 0);
        end
        check("t6_saturated", conflict_cnt, 4'hF);
        mem_req = 0;
        cyc = 0;
        while (!if_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t6_if_served", if_ready, 1);
        check("t6_still_sat", conflict_cnt, 4'hF);
        if_req = 0;

        for (int e = 0; e < 10; e++) run_episode(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
